alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU for the ARMv8 core.
- Keeps the existing 4-bit ALUControl encoding.
- Adds shifts and an iterative unsigned multiply and divide, with a start/busy/done handshake.
- Sits in the execute stage. The control unit stalls the pipeline while busy=1.

Parameters:
- N, 64, datapath width in bits; must be ≥4 and a power of 2.
- SW, $clog2(N), shift-amount width, derived (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- start  in  1  request an operation; sampled only when busy==0.
- a  in  N  operand A.
- b  in  N  operand B.
- ALUControl  in  4  operation select, decoded at the sampling edge.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse: result is new this cycle.
- result  out  N  registered result; holds until the next completion.
- zero  out  1  registered (result == 0), updated together with result.
- negative, carry, overflow  out  1 each  present only with ALU_FLAGS_EN.

Behaviour:
- Reset values: busy=0, done=0, result=0, zero=1, flags=0, FSM=IDLE, counter=0.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (a-b); 0111 PASS B; 1100 NOR.
  - 0011 LSL: a << b[SW-1:0].
  - 0100 LSR: logical a >> b[SW-1:0].
  - 1000 MUL: low N bits of a*b, unsigned.
  - 1001 UDIV: a/b, unsigned, truncating.
  - Any other code: PASS A.
- All arithmetic is modulo 2^N. Upper bits of the shift amount are ignored.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE, start=1, single-cycle opcode:
  - result/zero/flags register at the sampling edge.
  - done=1 for the following cycle; FSM stays IDLE.
  - Back-to-back starts are accepted every cycle.
- IDLE, start=1, MUL or UDIV:
  - Latch a and b, load counter=N, go to MUL_RUN or DIV_RUN, busy=1.
- MUL_RUN: shift-add, one multiplier bit per cycle.
- DIV_RUN: restoring shift-subtract, one quotient bit per cycle.
- At each run-state edge the counter decrements. At the edge where it reaches 0:
  - result written, done=1 for the following cycle, busy=0, FSM returns to IDLE.
- MUL/UDIV latency: done is high in the cycle after the (N+1)th edge counted from the sampling edge inclusive. For N=64, done is high 65 cycles after start.
- UDIV with b==0: no iteration; result=0 at the sampling edge, done next cycle (ARMv8 semantics).
- start while busy=1: ignored. No queuing, and in-flight operand latches are unchanged.
- a, b, ALUControl may change freely while busy=1.
- reset asserted mid-operation: abort to IDLE. No done pulse; result returns to 0.
- done and busy are never both 1.
- done is never high without a preceding accepted start.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- When defined, the negative, carry and overflow ports exist and are registered with result:
  - negative = result[N-1].
  - ADD: carry = carry-out of bit N-1; overflow = signed overflow.
  - SUB: carry = 1 iff a ≥ b unsigned (ARM not-borrow); overflow = signed overflow.
  - All other ops: carry=0, overflow=0.
- When undefined, the three ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset checks:
  - Hold reset=0 for 2 cycles with start=1 → busy=0, done=0, result=0, zero=1.
  - Release reset, then ADD with a=64'h0123_4567, b=64'h89AB_CDEF → next cycle done=1, result=64'h8ACF_1356, zero=0.
- Back-to-back single-cycle ops:
  - SUB 0xCCCC…CC − 0xCCCC…CC → result=0, zero=1, carry=1 (flags build).
  - Next cycle, LSL a=1, b=64'h43 → result=8, using the shift-amount mask.
- MUL with a=64'hFFFF_FFFF_FFFF_FFFF, b=3:
  - busy=1 for 64 cycles; done exactly 65 cycles after start.
  - result=64'hFFFF_FFFF_FFFF_FFFD.
  - start pulses issued mid-run are ignored.
- UDIV cases:
  - a=100, b=7 → result=14 after 65 cycles.
  - a=5, b=0 → result=0, zero=1, done 1 cycle after start.
- Abort and overflow:
  - reset=0 at cycle 20 of a MUL → no done, busy=0, result=0.
  - Next, ADD 64'h7FFF…F + 1 → result=64'h8000…0, negative=1, overflow=1, carry=0.
- Width variant N=8:
  - MUL 8'd15 × 8'd17 → result=8'hFF, done 9 cycles after start.
  - UDIV 8'd200 / 8'd3 → result=66.

Source files
------------

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered execute-stage ALU with iterative unsigned MUL / UDIV.
//
// Optional feature macro: ALU_FLAGS_EN (adds negative/carry/overflow ports).
//
// Ports:
//   clk         in   1   clock, all state changes on the rising edge
//   reset       in   1   synchronous, active-low reset
//   start       in   1   operation request, only looked at while busy==0
//   a, b        in   N   operands
//   ALUControl  in   4   operation select (legacy 4-bit encoding)
//   busy        out  1   multi-cycle MUL/UDIV in flight
//   done        out  1   one-cycle pulse, result is new this cycle
//   result      out  N   registered result, held until the next completion
//   zero        out  1   registered (result == 0)
//   negative    out  1   result[N-1]                  (ALU_FLAGS_EN only)
//   carry       out  1   ADD carry-out / SUB not-borrow (ALU_FLAGS_EN only)
//   overflow    out  1   signed overflow for ADD/SUB   (ALU_FLAGS_EN only)
//   dbg_state   out  2   current FSM state (IDLE=0, MUL_RUN=1, DIV_RUN=2)
//
// Handshake: an operation is accepted at a rising edge where start==1 and
// busy==0. Single-cycle opcodes and UDIV by zero write result at that edge
// and pulse done in the following cycle. MUL and UDIV raise busy for N
// cycles, then write result and pulse done in the cycle after busy falls.
// start is ignored while busy==1; done and busy are never high together.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
`ifdef ALU_FLAGS_EN
    output logic         negative,
    output logic         carry,
    output logic         overflow,
`endif
    output logic [1:0]   dbg_state
);

    localparam int SW = $clog2(N);
    localparam int CW = SW + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_UDIV = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    // MUL: op_a = multiplicand (shifts left), op_b = multiplier (shifts right),
    //      acc = partial product.
    // DIV: op_a = dividend shifting out / quotient shifting in,
    //      op_b = divisor, acc = partial remainder.
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [N-1:0]   acc;

    logic [N-1:0]   sc_result;
`ifdef ALU_FLAGS_EN
    logic           sc_carry;
    logic           sc_ovf;
`endif

    logic [N-1:0]   mul_acc_next;
    logic [N:0]     div_rem_sh;
    logic [N:0]     div_diff;
    logic           div_ge;
    logic [N-1:0]   div_rem_next;
    logic [N-1:0]   div_quo_next;
    logic [N-1:0]   fin_val;

    assign dbg_state = state;

    // -----------------------------------------------------------------------
    // Single-cycle datapath
    // -----------------------------------------------------------------------
    always_comb begin
        sc_result = a;
        case (ALUControl)
            OP_AND:   sc_result = a & b;
            OP_OR:    sc_result = a | b;
            OP_ADD:   sc_result = a + b;
            OP_SUB:   sc_result = a - b;
            OP_PASSB: sc_result = b;
            OP_NOR:   sc_result = ~(a | b);
            OP_LSL:   sc_result = a << b[SW-1:0];
            OP_LSR:   sc_result = a >> b[SW-1:0];
            // MUL never completes here; UDIV only completes here for b==0,
            // where the architectural answer is 0.
            OP_MUL:   sc_result = '0;
            OP_UDIV:  sc_result = '0;
            default:  sc_result = a;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (ALUControl)
            OP_ADD: begin
                // A wrapped unsigned sum is smaller than either operand.
                sc_carry = (sc_result < a);
                sc_ovf   = (a[N-1] == b[N-1]) && (sc_result[N-1] != a[N-1]);
            end
            OP_SUB: begin
                sc_carry = (a >= b);
                sc_ovf   = (a[N-1] != b[N-1]) && (sc_result[N-1] != a[N-1]);
            end
            default: begin
                sc_carry = 1'b0;
                sc_ovf   = 1'b0;
            end
        endcase
    end
`endif

    // -----------------------------------------------------------------------
    // Iteration step for the multi-cycle operations
    // -----------------------------------------------------------------------
    always_comb begin
        mul_acc_next = acc + (op_b[0] ? op_a : '0);

        // Restoring division: the partial remainder is always below the
        // divisor, so the shifted value fits N+1 bits and the top bit of the
        // difference is a clean "went negative" indicator.
        div_rem_sh   = {acc, op_a[N-1]};
        div_diff     = div_rem_sh - {1'b0, op_b};
        div_ge       = ~div_diff[N];
        div_rem_next = div_ge ? div_diff[N-1:0] : div_rem_sh[N-1:0];
        div_quo_next = {op_a[N-2:0], div_ge};

        fin_val      = (state == MUL_RUN) ? mul_acc_next : div_quo_next;
    end

    // -----------------------------------------------------------------------
    // Control FSM and all registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
`ifdef ALU_FLAGS_EN
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ALUControl == OP_MUL) begin
                            op_a  <= a;
                            op_b  <= b;
                            acc   <= '0;
                            cnt   <= CW'(N);
                            busy  <= 1'b1;
                            state <= MUL_RUN;
                        end else if (ALUControl == OP_UDIV && b != '0) begin
                            op_a  <= a;
                            op_b  <= b;
                            acc   <= '0;
                            cnt   <= CW'(N);
                            busy  <= 1'b1;
                            state <= DIV_RUN;
                        end else begin
                            result   <= sc_result;
                            zero     <= (sc_result == '0);
`ifdef ALU_FLAGS_EN
                            negative <= sc_result[N-1];
                            carry    <= sc_carry;
                            overflow <= sc_ovf;
`endif
                            done     <= 1'b1;
                        end
                    end
                end

                MUL_RUN, DIV_RUN: begin
                    if (state == MUL_RUN) begin
                        acc  <= mul_acc_next;
                        op_a <= op_a << 1;
                        op_b <= op_b >> 1;
                    end else begin
                        acc  <= div_rem_next;
                        op_a <= div_quo_next;
                    end
                    cnt <= cnt - CW'(1);
                    // Last iteration: this edge brings the counter to zero.
                    if (cnt == CW'(1)) begin
                        result   <= fin_val;
                        zero     <= (fin_val == '0);
`ifdef ALU_FLAGS_EN
                        negative <= fin_val[N-1];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
`endif
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (N=64 and N=8 instances).
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LSL   = 4'b0011;
    localparam logic [3:0] OP_LSR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [63:0] a, b;
    logic [3:0]  ctl;
    logic        busy, done, zero;
    logic [63:0] result;
    logic [1:0]  dbg_state;
    logic        negative, carry, overflow;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [3:0]  ctl8;
    logic        busy8, done8, zero8;
    logic [7:0]  result8;
    logic [1:0]  dbg_state8;
    logic        negative8, carry8, overflow8;

`ifndef ALU_FLAGS_EN
    assign negative  = 1'b0;
    assign carry     = 1'b0;
    assign overflow  = 1'b0;
    assign negative8 = 1'b0;
    assign carry8    = 1'b0;
    assign overflow8 = 1'b0;
`endif

    alu_seq #(.N(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .ALUControl (ctl),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
`ifdef ALU_FLAGS_EN
        .negative   (negative),
        .carry      (carry),
        .overflow   (overflow),
`endif
        .dbg_state  (dbg_state)
    );

    alu_seq #(.N(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .ALUControl (ctl8),
        .busy       (busy8),
        .done       (done8),
        .result     (result8),
        .zero       (zero8),
`ifdef ALU_FLAGS_EN
        .negative   (negative8),
        .carry      (carry8),
        .overflow   (overflow8),
`endif
        .dbg_state  (dbg_state8)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [66:0] exp_q[$];   // {negative, carry, overflow, result}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [3:0] c, input logic [63:0] x,
                                               input logic [63:0] y, input int w);
        logic [63:0] m;
        logic [63:0] r;
        int sh;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        x  = x & m;
        y  = y & m;
        sh = int'(y % 64'(w));
        case (c)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_ADD:   r = x + y;
            OP_SUB:   r = x - y;
            OP_PASSB: r = y;
            OP_NOR:   r = ~(x | y);
            OP_LSL:   r = x << sh;
            OP_LSR:   r = x >> sh;
            OP_MUL:   r = x * y;
            OP_UDIV:  r = (y == 64'd0) ? 64'd0 : x / y;
            default:  r = x;
        endcase
        return r & m;
    endfunction

    function automatic logic signed [127:0] sext(input logic [63:0] x);
        return $signed({{64{x[63]}}, x});
    endfunction

    // Flags for the 64-bit instance: carry/overflow mean the exact answer
    // does not fit the 64-bit result as unsigned/signed respectively.
    function automatic logic [2:0] ref_flags(input logic [3:0] c, input logic [63:0] x,
                                             input logic [63:0] y, input logic [63:0] r);
        logic [127:0]        wu;
        logic signed [127:0] ws;
        logic cf, vf;
        cf = 1'b0;
        vf = 1'b0;
        if (c == OP_ADD) begin
            wu = {64'd0, x} + {64'd0, y};
            ws = sext(x) + sext(y);
            cf = (wu != {64'd0, r});
            vf = (ws != sext(r));
        end else if (c == OP_SUB) begin
            ws = sext(x) - sext(y);
            cf = (x >= y);
            vf = (ws != sext(r));
        end
        return {r[63], cf, vf};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns the number of cycles until done
    // (1 = next cycle). Operands are scrambled while the op is in flight.
    task automatic run_op(input logic [3:0] c, input logic [63:0] x, input logic [63:0] y,
                          output int lat);
        ctl   = c;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (done !== 1'b1 && lat < 200) begin
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            ctl = 4'($urandom_range(0, 15));
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                           output int lat);
        ctl8   = c;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat    = 1;
        while (done8 !== 1'b1 && lat < 50) begin
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            ctl8 = 4'($urandom_range(0, 15));
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_flags(input string name, input logic [2:0] exp);
`ifdef ALU_FLAGS_EN
        check({name, "_nzcv"}, {61'd0, negative, carry, overflow}, {61'd0, exp});
`else
        if (exp === 3'bxxx) $display("unused %s", name);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  c;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] r;
        logic        z;
        logic [2:0]  ncv;
    } vec_t;

    vec_t tbl[14];

    logic [3:0] sc_ops[10];

    // Watchdog: fail loudly rather than hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        int stray;
        logic [66:0] e;
        logic [63:0] rx, ry, rr;
        logic [3:0]  rc;
        logic [7:0]  r8x, r8y;

        tbl[0]  = '{OP_ADD,   64'h0123_4567, 64'h89AB_CDEF, 64'h8ACF_1356, 1'b0, 3'b000};
        tbl[1]  = '{OP_SUB,   {16{4'hC}}, {16{4'hC}}, 64'h0, 1'b1, 3'b010};
        tbl[2]  = '{OP_LSL,   64'h1, 64'h43, 64'h8, 1'b0, 3'b000};
        tbl[3]  = '{OP_AND,   64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 3'b000};
        tbl[4]  = '{OP_OR,    64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 3'b000};
        tbl[5]  = '{OP_NOR,   64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b100};
        tbl[6]  = '{OP_PASSB, 64'h5, 64'h9, 64'h9, 1'b0, 3'b000};
        tbl[7]  = '{OP_LSR,   64'h8000_0000_0000_0000, 64'd63, 64'h1, 1'b0, 3'b000};
        tbl[8]  = '{OP_LSR,   64'h100, 64'h44, 64'h10, 1'b0, 3'b000};
        tbl[9]  = '{4'b0101,  64'h1234, 64'h5, 64'h1234, 1'b0, 3'b000};
        tbl[10] = '{4'b1111,  64'h0, 64'h77, 64'h0, 1'b1, 3'b000};
        tbl[11] = '{OP_ADD,   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 3'b010};
        tbl[12] = '{OP_ADD,   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 3'b101};
        tbl[13] = '{OP_SUB,   64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b100};

        sc_ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_NOR, OP_LSL, OP_LSR,
                   4'b0101, 4'b1111};

        // ---- reset held with start asserted ----
        reset  = 1'b0;
        start  = 1'b1;
        a      = 64'h1234;
        b      = 64'h5678;
        ctl    = OP_ADD;
        start8 = 1'b1;
        a8     = 8'd3;
        b8     = 8'd4;
        ctl8   = OP_MUL;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_done",   {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_zero",   {63'd0, zero}, 64'd1);
        check("rst_state",  {62'd0, dbg_state}, 64'd0);
        check_flags("rst", 3'b000);
        check("rst8_busy",   {63'd0, busy8}, 64'd0);
        check("rst8_result", {56'd0, result8}, 64'd0);
        check("rst8_zero",   {63'd0, zero8}, 64'd1);

        reset  = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        check("idle_done", {63'd0, done}, 64'd0);

        // ---- table, applied back-to-back one op per cycle ----
        for (int i = 0; i < 14; i++) begin
            ctl   = tbl[i].c;
            a     = tbl[i].x;
            b     = tbl[i].y;
            start = 1'b1;
            @(negedge clk);
            check($sformatf("tbl%0d_done", i),   {63'd0, done}, 64'd1);
            check($sformatf("tbl%0d_busy", i),   {63'd0, busy}, 64'd0);
            check($sformatf("tbl%0d_result", i), result, tbl[i].r);
            check($sformatf("tbl%0d_zero", i),   {63'd0, zero}, {63'd0, tbl[i].z});
            check_flags($sformatf("tbl%0d", i), tbl[i].ncv);
        end
        start = 1'b0;
        @(negedge clk);
        check("tbl_done_drop", {63'd0, done}, 64'd0);

        // ---- random single-cycle stream against the model ----
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                start = 1'b0;
                @(negedge clk);
                check("rnd_idle_done", {63'd0, done}, 64'd0);
            end else begin
                rc    = sc_ops[$urandom_range(0, 9)];
                rx    = {$urandom, $urandom};
                ry    = ($urandom_range(0, 3) == 0) ? rx : {$urandom, $urandom};
                ctl   = rc;
                a     = rx;
                b     = ry;
                start = 1'b1;
                rr    = ref_result(rc, rx, ry, 64);
                exp_q.push_back({ref_flags(rc, rx, ry, rr), rr});
                @(negedge clk);
                e = exp_q.pop_front();
                check("rnd_done",   {63'd0, done}, 64'd1);
                check("rnd_result", result, e[63:0]);
                check("rnd_zero",   {63'd0, zero}, {63'd0, (e[63:0] == 64'd0)});
                check_flags("rnd", e[66:64]);
            end
        end
        start = 1'b0;
        @(negedge clk);

        // ---- MUL all-ones x 3 with ignored start pulses mid-run ----
        ctl   = OP_MUL;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        b     = 64'd3;
        start = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            start = (cyc % 20 == 10);
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            ctl   = ((cyc / 20) % 2 == 0) ? OP_MUL : OP_ADD;
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_busy_window", 64'(bad), 64'd0);
        check("mul_done_65",     {63'd0, done}, 64'd1);
        check("mul_busy_off",    {63'd0, busy}, 64'd0);
        check("mul_result",      result, 64'hFFFF_FFFF_FFFF_FFFD);
        check_flags("mul", 3'b100);
        @(negedge clk);
        check("mul_done_pulse", {63'd0, done}, 64'd0);
        check("mul_no_restart", {63'd0, busy}, 64'd0);

        // ---- UDIV ----
        run_op(OP_UDIV, 64'd100, 64'd7, lat);
        check("div_lat",    64'(lat), 64'd65);
        check("div_result", result, 64'd14);
        check("div_busy",   {63'd0, busy}, 64'd0);
        run_op(OP_UDIV, 64'd5, 64'd0, lat);
        check("div0_lat",    64'(lat), 64'd1);
        check("div0_result", result, 64'd0);
        check("div0_zero",   {63'd0, zero}, 64'd1);

        // ---- abort a MUL with reset at cycle 20 ----
        run_op(OP_ADD, 64'd40, 64'd2, lat);
        check("pre_abort_result", result, 64'd42);
        ctl   = OP_MUL;
        a     = 64'd123;
        b     = 64'd456;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_busy",   {63'd0, busy}, 64'd0);
        check("abort_done",   {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_zero",   {63'd0, zero}, 64'd1);
        check("abort_state",  {62'd0, dbg_state}, 64'd0);
        stray = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        check("abort_no_done", 64'(stray), 64'd0);

        run_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
        check("ovf_lat",    64'(lat), 64'd1);
        check("ovf_result", result, 64'h8000_0000_0000_0000);
        check_flags("ovf", 3'b101);

        // ---- random MUL / UDIV ----
        for (int i = 0; i < 8; i++) begin
            rc = (i % 2 == 0) ? OP_MUL : OP_UDIV;
            rx = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       ry = 64'd0;
                1:       ry = 64'($urandom_range(1, 1000));
                2:       ry = {32'd0, $urandom};
                default: ry = {$urandom, $urandom};
            endcase
            rr = ref_result(rc, rx, ry, 64);
            run_op(rc, rx, ry, lat);
            check("rmd_lat", 64'(lat), (rc == OP_UDIV && ry == 64'd0) ? 64'd1 : 64'd65);
            check("rmd_result", result, rr);
            check("rmd_zero", {63'd0, zero}, {63'd0, (rr == 64'd0)});
        end

        // ---- N=8 instance ----
        run_op8(OP_MUL, 8'd15, 8'd17, lat);
        check("n8_mul_lat",    64'(lat), 64'd9);
        check("n8_mul_result", {56'd0, result8}, 64'hFF);
        run_op8(OP_UDIV, 8'd200, 8'd3, lat);
        check("n8_div_lat",    64'(lat), 64'd9);
        check("n8_div_result", {56'd0, result8}, 64'd66);
        run_op8(OP_ADD, 8'd200, 8'd100, lat);
        check("n8_add_result", {56'd0, result8}, 64'd44);
        run_op8(OP_LSL, 8'd1, 8'h0B, lat);
        check("n8_lsl_result", {56'd0, result8}, 64'd8);
        for (int i = 0; i < 16; i++) begin
            rc  = (i % 2 == 0) ? OP_MUL : OP_UDIV;
            r8x = 8'($urandom);
            r8y = (i % 5 == 1) ? 8'd0 : 8'($urandom);
            rr  = ref_result(rc, {56'd0, r8x}, {56'd0, r8y}, 8);
            run_op8(rc, r8x, r8y, lat);
            check("n8_rnd_lat", 64'(lat), (rc == OP_UDIV && r8y == 8'd0) ? 64'd1 : 64'd9);
            check("n8_rnd_result", {56'd0, result8}, rr);
        end

        // ---- final report ----
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
